// File: rtl/rob_ar_arbiter.sv
// rob_ar_arbiter: shares one reorder_buffer AR/R slave port between NUM_REQ
// read requesters.
//   AR side: round-robin winner into a single-entry grant register (IDLE/ISSUE).
//   R side : the reorder_buffer answers in AR-issue order, so a tag FIFO of
//            requester indices steers each returned beat to its originator.
//   Credit : in-flight reads are capped at MAX_OUTST (reorder_buffer has 16 slots).
// Optional feature, enabled by defining ROB_ARB_PERF_EN: a saturating 16-bit
// stall counter (stall_cnt_o) with a synchronous clear input (perf_clr_i).
module rob_ar_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_OUTST  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ*4-1:0]    req_arid_i,
  input  logic [NUM_REQ-1:0]      req_arvalid_i,
  output logic [NUM_REQ-1:0]      req_arready_o,
  output logic [DATA_WIDTH-1:0]   req_rdata_o,
  output logic [3:0]              req_rid_o,
  output logic [NUM_REQ-1:0]      req_rvalid_o,
  input  logic [NUM_REQ-1:0]      req_rready_i,
  output logic [3:0]              rob_arid_o,
  output logic                    rob_arvalid_o,
  input  logic                    rob_arready_i,
  input  logic [DATA_WIDTH-1:0]   rob_rdata_i,
  input  logic [3:0]              rob_rid_i,
  input  logic                    rob_rvalid_i,
  output logic                    rob_rready_o
`ifdef ROB_ARB_PERF_EN
  ,
  output logic [15:0]             stall_cnt_o,
  input  logic                    perf_clr_i
`endif
);

  // Tag width holds a requester index; FIFO pointers carry one extra wrap bit
  // so that full and empty are distinguishable when the index bits match.
  localparam int TAG_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CRED_W = $clog2(MAX_OUTST + 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [TAG_W-1:0]    rr_ptr_q;
  logic [3:0]          id_q;
  logic [CRED_W-1:0]   credit_q;

  logic [TAG_W-1:0]    tag_mem [MAX_OUTST];
  logic [PTR_W:0]      wr_ptr_q, rd_ptr_q;

  logic [TAG_W-1:0]    winner;
  logic                winner_found;
  logic                credit_full;
  logic                ar_hs;
  logic                r_hs;
  logic                fifo_empty;
  logic [TAG_W-1:0]    head_tag;

  // Advance a FIFO pointer, wrapping the index at MAX_OUTST and toggling the
  // wrap bit, so non-power-of-two depths behave correctly as well.
  function automatic logic [PTR_W:0] ptr_inc(input logic [PTR_W:0] p);
    logic [PTR_W:0] n;
    if (p[PTR_W-1:0] == PTR_W'(MAX_OUTST - 1)) begin
      n = {~p[PTR_W], {PTR_W{1'b0}}};
    end else begin
      n = p + (PTR_W + 1)'(1);
    end
    return n;
  endfunction

  assign credit_full = (credit_q == CRED_W'(MAX_OUTST));
  assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
  assign head_tag    = tag_mem[rd_ptr_q[PTR_W-1:0]];

  // Accept happens only in IDLE, with a requester waiting and a free credit.
  assign ar_hs = (state_q == S_IDLE) && winner_found && !credit_full;
  assign r_hs  = rob_rvalid_i && rob_rready_o;

  // Round-robin search: first valid requester at or above the pointer, wrapping.
  always_comb begin
    // NOTE: every variable written here gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    winner       = '0;
    winner_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!winner_found && req_arvalid_i[(int'(rr_ptr_q) + i) % NUM_REQ]) begin
        winner_found = 1'b1;
        winner       = TAG_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      end
    end
  end

  // FSM next state plus all handshake outputs; reset forces every output low.
  always_comb begin
    state_d       = state_q;
    req_arready_o = '0;
    req_rvalid_o  = '0;
    req_rdata_o   = '0;
    req_rid_o     = '0;
    rob_arvalid_o = 1'b0;
    rob_arid_o    = '0;
    rob_rready_o  = 1'b0;
    if (rst_n) begin
      req_rdata_o = rob_rdata_i;
      req_rid_o   = rob_rid_i;
      unique case (state_q)
        S_IDLE: begin
          if (ar_hs) begin
            req_arready_o[winner] = 1'b1;
            state_d               = S_ISSUE;
          end
        end
        S_ISSUE: begin
          rob_arvalid_o = 1'b1;
          rob_arid_o    = id_q;
          if (rob_arready_i) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
      // Only the requester at the FIFO head may see or acknowledge R beats.
      if (!fifo_empty) begin
        req_rvalid_o[head_tag] = rob_rvalid_i;
        rob_rready_o           = req_rready_i[head_tag];
      end
    end
  end

  // State register, grant ID register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
    end else begin
      state_q <= state_d;
      if (ar_hs) begin
        id_q     <= req_arid_i[4*int'(winner) +: 4];
        rr_ptr_q <= (winner == TAG_W'(NUM_REQ - 1)) ? '0 : winner + TAG_W'(1);
      end
    end
  end

  // Outstanding-read credit: +1 on accept, -1 on R handshake, both cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q <= '0;
    end else begin
      unique case ({ar_hs, r_hs})
        2'b10:   credit_q <= credit_q + CRED_W'(1);
        2'b01:   credit_q <= credit_q - CRED_W'(1);
        default: credit_q <= credit_q;
      endcase
    end
  end

  // Tag FIFO storage; never read while empty, so the contents need no reset.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately left out of reset; the reset
    // pointers mark it empty, which keeps it mappable onto plain RAM.
    if (ar_hs) begin
      tag_mem[wr_ptr_q[PTR_W-1:0]] <= winner;
    end
  end

  // Tag FIFO pointers; credit gating guarantees no push while full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (ar_hs) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (r_hs) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
    end
  end

`ifdef ROB_ARB_PERF_EN
  // Saturating count of cycles where a requester waits on exhausted credit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
    end else if (perf_clr_i) begin
      stall_cnt_o <= '0;
    end else if (credit_full && (|req_arvalid_i) && (stall_cnt_o != 16'hFFFF)) begin
      stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end
`endif

endmodule
